// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial magnitude compare sequencer: feeds {A bit, B bit} MSB-first to a
// 1-bit comparator and stops at the first bit its k/l flags report as unequal.
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              k,
    input  logic              l,
    output logic [1:0]        s,
    output logic              busy,
    output logic              done,
    output logic              lt,
    output logic              gt,
    output logic              eq,
    output logic              err,
    output logic [IDXW:0]     bits_used
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [IDXW-1:0]  idx;

    // The shift registers hold only the bits not yet presented on s, so the
    // next pair to present always sits in their MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            err       <= 1'b0;
            bits_used <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s    <= 2'b00;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        sh_a      <= a << 1;
                        sh_b      <= b << 1;
                        s         <= {a[WIDTH-1], b[WIDTH-1]};
                        idx       <= IDXW'(WIDTH - 1);
                        bits_used <= '0;
                        lt        <= 1'b0;
                        gt        <= 1'b0;
                        eq        <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end

                SCAN: begin
                    bits_used <= bits_used + 1'b1;
                    case ({k, l})
                        2'b01:   lt  <= 1'b1;
                        2'b10:   gt  <= 1'b1;
                        2'b00:   err <= 1'b1;
                        default: if (idx == '0) eq <= 1'b1;
                    endcase
                    if ({k, l} != 2'b11 || idx == '0) begin
                        s     <= 2'b00;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        s    <= {sh_a[WIDTH-1], sh_b[WIDTH-1]};
                        sh_a <= sh_a << 1;
                        sh_b <= sh_b << 1;
                        idx  <= idx - 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Randomised bench for serial_mag_compare_ctrl with a behavioural comparator
// and a whole-word reference model of the compare result.
module tb_serial_mag_compare_ctrl;

    localparam int WIDTH = 8;
    localparam int IDXW  = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             k;
    logic             l;
    logic [1:0]       s;
    logic             busy, done, lt, gt, eq, err;
    logic [IDXW:0]    bits_used;
    logic             bad_flags = 1'b0;

    int checks = 0;
    int passes = 0;

    serial_mag_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .k(k), .l(l), .s(s), .busy(busy), .done(done),
        .lt(lt), .gt(gt), .eq(eq), .err(err), .bits_used(bits_used)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit comparator; bad_flags injects the illegal k=0,l=0 pair.
    assign k = bad_flags ? 1'b0 : !(s == 2'b01);
    assign l = bad_flags ? 1'b0 : !(s == 2'b10);

    function automatic int first_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int i = 1; i <= WIDTH; i++)
            if (d[WIDTH-i]) return i;
        return 0;
    endfunction

    task automatic run_compare(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input int inject, input bit spam, input string tag);
        int  p, exp_bits, cyc;
        bit  exp_lt, exp_gt, exp_eq, exp_err, seen;
        logic [1:0] exp_s;
        p        = first_diff(va, vb);
        exp_bits = (p == 0) ? WIDTH : p;
        exp_lt   = va < vb;
        exp_gt   = va > vb;
        exp_eq   = va == vb;
        exp_err  = 1'b0;
        if (inject > 0 && inject <= exp_bits) begin
            exp_err  = 1'b1;
            exp_lt   = 1'b0;
            exp_gt   = 1'b0;
            exp_eq   = 1'b0;
            exp_bits = inject;
        end

        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(negedge clk);
        if (!spam) start = 1'b0;
        a = ~va;
        b = ~vb;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= WIDTH + 3; c++) begin
            if (done) begin
                seen = 1'b1;
                cyc  = c;
                break;
            end
            checks++;
            if (busy !== 1'b1)
                $display("[TB] FAIL %s busy cyc%0d: got %b want 1", tag, c, busy);
            else passes++;
            if (c <= WIDTH) begin
                exp_s = {va[WIDTH-c], vb[WIDTH-c]};
                checks++;
                if (s !== exp_s)
                    $display("[TB] FAIL %s s cyc%0d: got %b want %b", tag, c, s, exp_s);
                else passes++;
            end
            if (c == 1) begin
                checks++;
                if ({lt, gt, eq, err} !== 4'b0000)
                    $display("[TB] FAIL %s cleared: got %b want 0000", tag, {lt, gt, eq, err});
                else passes++;
            end
            bad_flags = (c == inject);
            @(negedge clk);
        end
        bad_flags = 1'b0;
        start = 1'b0;

        checks++;
        if (!seen)
            $display("[TB] FAIL %s timeout: no done within %0d cycles", tag, WIDTH + 3);
        else if (cyc - 1 != exp_bits)
            $display("[TB] FAIL %s latency: done after edge %0d want %0d", tag, cyc - 1, exp_bits);
        else passes++;

        checks++;
        if ({lt, gt, eq, err} !== {exp_lt, exp_gt, exp_eq, exp_err})
            $display("[TB] FAIL %s result lt/gt/eq/err: got %b want %b", tag,
                     {lt, gt, eq, err}, {exp_lt, exp_gt, exp_eq, exp_err});
        else passes++;
        checks++;
        if (bits_used !== (IDXW+1)'(exp_bits))
            $display("[TB] FAIL %s bits_used: got %0d want %0d", tag, bits_used, exp_bits);
        else passes++;
        checks++;
        if (busy !== 1'b0 || s !== 2'b00)
            $display("[TB] FAIL %s done-cycle busy/s: got %b/%b want 0/00", tag, busy, s);
        else passes++;

        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || s !== 2'b00)
            $display("[TB] FAIL %s after done: done/busy/s got %b/%b/%b want 0/0/00", tag, done, busy, s);
        else passes++;
        checks++;
        if ({lt, gt, eq, err} !== {exp_lt, exp_gt, exp_eq, exp_err} || bits_used !== (IDXW+1)'(exp_bits))
            $display("[TB] FAIL %s held result: got %b/%0d want %b/%0d", tag, {lt, gt, eq, err},
                     bits_used, {exp_lt, exp_gt, exp_eq, exp_err}, exp_bits);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({s, busy, done, lt, gt, eq, err} !== 9'b0 || bits_used !== '0)
            $display("[TB] FAIL reset outputs: got s=%b busy=%b done=%b res=%b bits=%0d want all 0",
                     s, busy, done, {lt, gt, eq, err}, bits_used);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL idle after reset: busy/done got %b/%b want 0/0", busy, done);
        else passes++;
    endtask

    task automatic test_directed();
        run_compare(8'hA5, 8'hA5, 0, 1'b0, "eq_A5");
        run_compare(8'h80, 8'h7F, 0, 1'b0, "gt_msb");
        run_compare(8'h12, 8'h13, 0, 1'b0, "lt_lsb");
        run_compare(8'h00, 8'hFF, 0, 1'b0, "lt_msb");
        run_compare(8'hFF, 8'hFF, 0, 1'b0, "eq_FF");
    endtask

    task automatic test_err_inject();
        run_compare(8'hF0, 8'hF0, 3, 1'b0, "err_c3");
        run_compare(8'h3C, 8'h3D, 8, 1'b0, "err_c8");
    endtask

    task automatic test_start_spam();
        run_compare(8'h01, 8'h00, 0, 1'b1, "spam_gt");
        run_compare(8'h40, 8'h41, 0, 1'b0, "after_spam");
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        a = 8'h5A;
        b = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s, busy, done, lt, gt, eq, err} !== 9'b0 || bits_used !== '0)
            $display("[TB] FAIL midscan reset: got s=%b busy=%b done=%b res=%b bits=%0d want all 0",
                     s, busy, done, {lt, gt, eq, err}, bits_used);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("[TB] FAIL midscan no-done c%0d: done/busy got %b/%b want 0/0", i, done, busy);
            else passes++;
            if (i == 1) rst_n = 1'b1;
        end
        run_compare(8'h5A, 8'h5A, 0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb;
        int mode;
        for (int n = 0; n < 24; n++) begin
            ra   = WIDTH'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0)
                run_compare(ra, ra, $urandom_range(1, WIDTH), 1'b0, "rand_err");
            else
                run_compare(ra, rb, 0, 1'b0, "rand");
        end
    endtask

    task automatic test_back_to_back();
        run_compare(8'hC3, 8'hC2, 0, 1'b0, "b2b_1");
        run_compare(8'hC2, 8'hC3, 0, 1'b0, "b2b_2");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_err_inject();
        test_start_spam();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
